// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready on both sides,
// a detect-only mode and saturating single/double error counters.
module hamming_secded_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    localparam int PAR_W  = $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1)))),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [DATA_W-1:0] data_out,
    output logic [PAR_W-1:0]  syndrome,
    output logic [1:0]        err_flag,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double,
    input  logic              cnt_clr
);

    localparam logic [PAR_W-1:0]  MAX_POS = PAR_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] TOP_BIT = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] ONE     = CODE_W'(1);

    localparam logic [1:0] FLAG_NONE   = 2'b00;
    localparam logic [1:0] FLAG_SINGLE = 2'b01;
    localparam logic [1:0] FLAG_DOUBLE = 2'b10;
    localparam logic [1:0] FLAG_PARITY = 2'b11;

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic              s1_ce;

    logic              s2_adv;
    logic              in_fire;
    logic              out_fire;

    logic [PAR_W-1:0]  in_syn;
    logic              in_par;
    logic [CODE_W-1:0] fixed_code;
    logic [DATA_W-1:0] fixed_data;
    logic [1:0]        fixed_flag;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Syndrome bit b is the XOR of every position whose index has bit b set.
    for (genvar b = 0; b < PAR_W; b++) begin : g_syn
        logic [CODE_W-2:0] sel;
        for (genvar i = 0; i < CODE_W - 1; i++) begin : g_pos
            if ((((i + 1) >> b) & 1) == 1) begin : g_on
                assign sel[i] = code_in[i];
            end else begin : g_off
                assign sel[i] = 1'b0;
            end
        end
        assign in_syn[b] = ^sel;
    end

    assign in_par = ^code_in;

    always_comb begin
        logic [CODE_W-1:0] flip;
        flip       = '0;
        fixed_flag = FLAG_NONE;
        if (s1_syn == '0) begin
            if (s1_par) begin
                fixed_flag = FLAG_PARITY;
                flip       = TOP_BIT;
            end
        end else if (s1_par && (s1_syn <= MAX_POS)) begin
            fixed_flag = FLAG_SINGLE;
            flip       = ONE << (s1_syn - 1'b1);
        end else begin
            fixed_flag = FLAG_DOUBLE;
        end
        fixed_code = s1_ce ? (s1_code ^ flip) : s1_code;
    end

    // Data bit k lives at the k-th non-power-of-2 position, i.e. position g maps to g-clog2(g)-1.
    for (genvar g = 1; g < CODE_W; g++) begin : g_data
        if ((g & (g - 1)) != 0) begin : g_take
            assign fixed_data[g - $clog2(g) - 1] = fixed_code[g-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_ce    <= 1'b0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_adv);
            if (in_fire) begin
                s1_code <= code_in;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
                s1_ce   <= correct_en;
            end
        end
    end

    // Output registers only move when the consumer takes the word or stage 2 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            code_out  <= '0;
            data_out  <= '0;
            syndrome  <= '0;
            err_flag  <= FLAG_NONE;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                code_out <= fixed_code;
                data_out <= fixed_data;
                syndrome <= s1_syn;
                err_flag <= fixed_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (cnt_clr) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_fire) begin
            if ((err_flag == FLAG_SINGLE || err_flag == FLAG_PARITY) && cnt_single != '1)
                cnt_single <= cnt_single + 1'b1;
            if (err_flag == FLAG_DOUBLE && cnt_double != '1)
                cnt_double <= cnt_double + 1'b1;
        end
    end

endmodule
